// File: rtl/fmul_share_arbiter.sv
// Time-shares one pipelined f_mult among N_REQ requesters and routes each result back by tag.
// Optional: define FMUL_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
`ifndef FLEN
`define FLEN 32
`endif

module fmul_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_vld,
  input  logic [N_REQ*`FLEN-1:0]        req_a,
  input  logic [N_REQ*`FLEN-1:0]        req_b,
  output logic [N_REQ-1:0]              req_rdy,
  output logic [`FLEN-1:0]              mul_a,
  output logic [`FLEN-1:0]              mul_b,
  output logic                          mul_up_valid,
  input  logic [`FLEN-1:0]              mul_res,
  input  logic                          mul_down_valid,
  input  logic                          mul_busy,
  input  logic                          mul_error,
  output logic [N_REQ-1:0]              rsp_vld,
  output logic [`FLEN-1:0]              rsp_res,
  output logic [$clog2(MUL_LAT+2)-1:0]  inflight,
  output logic                          err_sticky
);

  localparam int FW  = `FLEN;
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(MUL_LAT+2);

  typedef enum logic {DRAIN, RUN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   gnt_id, scan_idx;
  logic             gnt_any, grant_en, hs, run;
  logic [N_REQ-1:0] gnt;
  logic [FW-1:0]    sel_a, sel_b;

  logic [FW-1:0]    mul_a_q, mul_b_q, rsp_res_q;
  logic             mul_up_valid_q, err_q;
  logic [IDW-1:0]   iss_id_q;
  logic [MUL_LAT-1:0] tag_vld_q;
  logic [IDW-1:0]   tag_id_q [MUL_LAT];
  logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic             last_vld, retire, err_ev;
  logic [IDW-1:0]   last_id;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DRAIN: begin
        if (cnt_q == CW'(MUL_LAT)) state_d = RUN;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      RUN:     state_d = RUN;
      default: state_d = DRAIN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DRAIN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run      = (state_q == RUN);
  assign grant_en = run && !mul_busy;

  // Scan from the highest offset down so the nearest valid requester after ptr wins.
  always_comb begin
    gnt      = '0;
    gnt_id   = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    for (int o = N_REQ-1; o >= 0; o--) begin
      scan_idx = wrap_add(ptr_q, o);
      if (req_vld[scan_idx]) begin
        gnt_id  = scan_idx;
        gnt_any = 1'b1;
      end
    end
    if (grant_en && gnt_any) gnt[gnt_id] = 1'b1;
  end

  assign hs      = |gnt;
  assign req_rdy = gnt;

`ifdef FMUL_ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ptr_q <= '0;
    else if (hs) ptr_q <= wrap_add(gnt_id, 1);
  end
`endif

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        sel_a = req_a[k*FW +: FW];
        sel_b = req_b[k*FW +: FW];
      end
    end
  end

  // The issue register is the first tag slot; MUL_LAT more stages line up with mul_down_valid.
  assign last_vld = tag_vld_q[MUL_LAT-1];
  assign last_id  = tag_id_q[MUL_LAT-1];
  assign retire   = run && last_vld && mul_down_valid;
  assign err_ev   = run && ((mul_down_valid ^ last_vld) || (mul_down_valid && mul_error));

  always_comb begin
    rsp_vld_d = '0;
    if (retire) rsp_vld_d[last_id] = 1'b1;
    inflight_d = inflight_q;
    case ({hs, last_vld})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      mul_up_valid_q <= 1'b0;
      iss_id_q       <= '0;
      tag_vld_q      <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_id_q[i] <= '0;
      rsp_vld_q      <= '0;
      rsp_res_q      <= '0;
      inflight_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      mul_up_valid_q <= hs;
      if (hs) begin
        mul_a_q  <= sel_a;
        mul_b_q  <= sel_b;
        iss_id_q <= gnt_id;
      end
      tag_vld_q[0] <= mul_up_valid_q;
      tag_id_q[0]  <= iss_id_q;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      rsp_vld_q <= rsp_vld_d;
      if (retire) rsp_res_q <= mul_res;
      inflight_q <= inflight_d;
      if (err_ev) err_q <= 1'b1;
    end
  end

  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign mul_up_valid = mul_up_valid_q;
  assign rsp_vld      = rsp_vld_q;
  assign rsp_res      = rsp_res_q;
  assign inflight     = inflight_q;
  assign err_sticky   = err_q;

endmodule
